// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the in-order issue scheduler.
//   ISSUE_QUEUE_ELEMENT : one decoded instruction waiting for issue
//   SB_REGS / REG_ZERO  : scoreboard size and the hard-wired zero register
package issue_scheduler_pkg;

    localparam int         SB_REGS  = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADDIU = 4'd1,
        OP_ORI   = 4'd2,
        OP_ADDU  = 4'd3,
        OP_LW    = 4'd4,
        OP_SW    = 4'd5
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] pc;
        logic        num1_need;
        logic [4:0]  num1_addr;
        logic [31:0] num1;
        logic        num2_need;
        logic [4:0]  num2_addr;
        logic [31:0] num2;
        logic        write_reg_need;
        logic [4:0]  write_reg_addr;
    } ISSUE_QUEUE_ELEMENT;

    // True when a writeback this cycle targets a real (non-zero) register a.
    function automatic logic wb_hit(input logic       wb_v,
                                    input logic [4:0] wb_a,
                                    input logic [4:0] a);
        return wb_v && (wb_a == a) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set when a writer
// issues and cleared when its writeback arrives.
//   clk, rst_n         : clock, synchronous active-low reset
//   set_en/set_addr    : mark register busy (issue of a writer)
//   clr_en/clr_addr    : mark register free (writeback)
//   lk_addr1/2, busy1/2: combinational lookups for the two source operands
module issue_scoreboard
    import issue_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] lk_addr1,
    input  logic [4:0] lk_addr2,
    output logic       busy1,
    output logic       busy2
);

    logic [SB_REGS-1:0] r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (clr_en && (clr_addr != REG_ZERO))
                r_busy[clr_addr] <= 1'b0;
            // Placed after the clear so a same-cycle set (newer writer) wins.
            if (set_en && (set_addr != REG_ZERO))
                r_busy[set_addr] <= 1'b1;
        end
    end

    assign busy1 = r_busy[lk_addr1];
    assign busy2 = r_busy[lk_addr2];

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue scheduler: circular FIFO of decoded elements; the head is
// released once both source operands are available, with operand values taken
// from the immediate, the writeback bypass or the register file.
//   enq_valid/enq_elem/enq_ready : decoder side
//   flush                        : discard all queued entries
//   rf_raddr*/rf_rdata*          : combinational register file reads (head)
//   wb_valid/wb_addr/wb_data     : writeback, clears scoreboard and bypasses
//   issue_valid/issue_elem/issue_ready : execute side
//   count                        : occupancy
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enq_valid,
    input  ISSUE_QUEUE_ELEMENT enq_elem,
    output logic               enq_ready,
    input  logic               flush,
    output logic [4:0]         rf_raddr1,
    output logic [4:0]         rf_raddr2,
    input  logic [31:0]        rf_rdata1,
    input  logic [31:0]        rf_rdata2,
    input  logic               wb_valid,
    input  logic [4:0]         wb_addr,
    input  logic [31:0]        wb_data,
    output logic               issue_valid,
    output ISSUE_QUEUE_ELEMENT issue_elem,
    input  logic               issue_ready,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    ISSUE_QUEUE_ELEMENT r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;

    ISSUE_QUEUE_ELEMENT w_head;
    logic               w_busy1, w_busy2;
    logic               w_ready1, w_ready2;
    logic [31:0]        w_val1, w_val2;
    logic               w_enq, w_iss;

    assign w_head    = r_mem[r_head];
    assign rf_raddr1 = w_head.num1_addr;
    assign rf_raddr2 = w_head.num2_addr;

    issue_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (w_iss && w_head.write_reg_need),
        .set_addr (w_head.write_reg_addr),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .lk_addr1 (w_head.num1_addr),
        .lk_addr2 (w_head.num2_addr),
        .busy1    (w_busy1),
        .busy2    (w_busy2)
    );

    assign w_ready1 = !w_head.num1_need || (w_head.num1_addr == REG_ZERO) ||
                      !w_busy1 || (wb_valid && (wb_addr == w_head.num1_addr));
    assign w_ready2 = !w_head.num2_need || (w_head.num2_addr == REG_ZERO) ||
                      !w_busy2 || (wb_valid && (wb_addr == w_head.num2_addr));

    always_comb begin
        w_val1 = w_head.num1;
        if (w_head.num1_need) begin
            if (w_head.num1_addr == REG_ZERO)
                w_val1 = 32'd0;
            else if (wb_hit(wb_valid, wb_addr, w_head.num1_addr))
                w_val1 = wb_data;
            else
                w_val1 = rf_rdata1;
        end
    end

    always_comb begin
        w_val2 = w_head.num2;
        if (w_head.num2_need) begin
            if (w_head.num2_addr == REG_ZERO)
                w_val2 = 32'd0;
            else if (wb_hit(wb_valid, wb_addr, w_head.num2_addr))
                w_val2 = wb_data;
            else
                w_val2 = rf_rdata2;
        end
    end

    always_comb begin
        issue_elem      = w_head;
        issue_elem.num1 = w_val1;
        issue_elem.num2 = w_val2;
    end

    assign enq_ready   = (r_count != FULL);
    assign issue_valid = (r_count != '0) && w_ready1 && w_ready2 && !flush;
    assign w_enq       = enq_valid && enq_ready && !flush;
    assign w_iss       = issue_valid && issue_ready;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (w_enq)
            r_mem[r_tail] <= enq_elem;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + PTR_W'(1);
            if (w_iss)
                r_head <= r_head + PTR_W'(1);
            if (w_enq && !w_iss)
                r_count <= r_count + (PTR_W+1)'(1);
            else if (w_iss && !w_enq)
                r_count <= r_count - (PTR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enq_valid;
    ISSUE_QUEUE_ELEMENT enq_elem;
    logic               enq_ready;
    logic               flush;
    logic [4:0]         rf_raddr1, rf_raddr2;
    logic [31:0]        rf_rdata1, rf_rdata2;
    logic               wb_valid;
    logic [4:0]         wb_addr;
    logic [31:0]        wb_data;
    logic               issue_valid;
    ISSUE_QUEUE_ELEMENT issue_elem;
    logic               issue_ready;
    logic [3:0]         count;

    int n_chk = 0;
    int n_fail = 0;

    issue_scheduler #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_elem(enq_elem),
        .enq_ready(enq_ready), .flush(flush), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_elem(issue_elem),
        .issue_ready(issue_ready), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        ISSUE_QUEUE_ELEMENT e;
        logic [4:0]  pre;
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        ev;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [9];

    function automatic ISSUE_QUEUE_ELEMENT mk(input op_e op, input logic [31:0] pc,
            input logic n1n, input logic [4:0] n1a, input logic [31:0] n1,
            input logic n2n, input logic [4:0] n2a, input logic [31:0] n2,
            input logic wn, input logic [4:0] wa);
        ISSUE_QUEUE_ELEMENT x;
        x.op = op; x.pc = pc;
        x.num1_need = n1n; x.num1_addr = n1a; x.num1 = n1;
        x.num2_need = n2n; x.num2_addr = n2a; x.num2 = n2;
        x.write_reg_need = wn; x.write_reg_addr = wa;
        return x;
    endfunction

    function automatic vec_t mkv(input ISSUE_QUEUE_ELEMENT e, input logic [4:0] pre,
            input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
            input logic [31:0] rd1, input logic [31:0] rd2,
            input logic ev, input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.e = e; v.pre = pre; v.wbv = wbv; v.wba = wba; v.wbd = wbd;
        v.rd1 = rd1; v.rd2 = rd2; v.ev = ev; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enq_valid = 1'b0; enq_elem = '0; flush = 1'b0;
        rf_rdata1 = '0; rf_rdata2 = '0; wb_valid = 1'b0; wb_addr = '0;
        wb_data = '0; issue_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    ISSUE_QUEUE_ELEMENT exp_e;

    initial begin
        // Operand-resolution table.
        vecs[0] = mkv(mk(OP_ORI, 32'h10, 1, 0, 0, 0, 0, 32'h5, 1, 2),
                      0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1, 32'h0, 32'h5);
        vecs[1] = mkv(mk(OP_NOP, 32'h14, 0, 4, 32'h11, 0, 7, 32'h22, 0, 0),
                      0, 0, 0, 0, 32'h1, 32'h2, 1, 32'h11, 32'h22);
        vecs[2] = mkv(mk(OP_ADDU, 32'h18, 1, 4, 0, 1, 7, 0, 1, 9),
                      0, 0, 0, 0, 32'hA, 32'hB, 1, 32'hA, 32'hB);
        vecs[3] = mkv(mk(OP_ADDIU, 32'h1C, 1, 4, 0, 0, 0, 32'h5, 1, 6),
                      4, 0, 0, 0, 32'h1, 32'h2, 0, 32'h1, 32'h5);
        vecs[4] = mkv(mk(OP_ADDIU, 32'h20, 1, 4, 0, 0, 0, 32'h5, 1, 6),
                      4, 1, 4, 32'h99, 32'h1, 32'h2, 1, 32'h99, 32'h5);
        vecs[5] = mkv(mk(OP_ADDU, 32'h24, 1, 6, 0, 1, 6, 0, 1, 1),
                      0, 1, 6, 32'h77, 32'h1, 32'h2, 1, 32'h77, 32'h77);
        vecs[6] = mkv(mk(OP_ADDU, 32'h28, 1, 0, 0, 1, 3, 0, 1, 1),
                      0, 1, 0, 32'h55, 32'h1, 32'h2, 1, 32'h0, 32'h2);
        vecs[7] = mkv(mk(OP_SW, 32'h2C, 0, 0, 32'h8, 1, 9, 0, 0, 0),
                      9, 1, 10, 32'h33, 32'h1, 32'h44, 0, 32'h8, 32'h44);
        vecs[8] = mkv(mk(OP_ADDIU, 32'h30, 0, 4, 32'h3, 0, 0, 32'h6, 1, 5),
                      4, 0, 0, 0, 32'h1, 32'h2, 1, 32'h3, 32'h6);

        do_reset();
        #1;
        chk("reset_count", 128'(count), 128'(0));
        chk("reset_issue_valid", 128'(issue_valid), 128'(0));
        chk("reset_enq_ready", 128'(enq_ready), 128'(1));

        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (vecs[i].pre != 5'd0) begin
                enq_valid = 1'b1;
                enq_elem  = mk(OP_ADDIU, 32'h100, 0, 0, 0, 0, 0, 0, 1, vecs[i].pre);
            end
            step();
            enq_valid = 1'b1; enq_elem = vecs[i].e; issue_ready = 1'b1;
            step();
            enq_valid = 1'b0; issue_ready = 1'b0;
            wb_valid = vecs[i].wbv; wb_addr = vecs[i].wba; wb_data = vecs[i].wbd;
            rf_rdata1 = vecs[i].rd1; rf_rdata2 = vecs[i].rd2;
            #1;
            exp_e = vecs[i].e; exp_e.num1 = vecs[i].e1; exp_e.num2 = vecs[i].e2;
            chk($sformatf("vec%0d_valid", i), 128'(issue_valid), 128'(vecs[i].ev));
            chk($sformatf("vec%0d_elem", i), 128'(issue_elem), 128'(exp_e));
            chk($sformatf("vec%0d_count", i), 128'(count), 128'(1));
            wb_valid = 1'b0;
        end

        // ORI issue sets busy[rt].
        do_reset();
        issue_ready = 1'b1; enq_valid = 1'b1;
        enq_elem = mk(OP_ORI, 32'h40, 1, 0, 0, 0, 0, 32'h5, 1, 9);
        step();
        enq_valid = 1'b0;
        step();
        chk("ori_busy_rt", 128'(dut.u_sb.r_busy[9]), 128'(1));

        // RAW stall, released by writeback bypass.
        do_reset();
        issue_ready = 1'b1; enq_valid = 1'b1;
        enq_elem = mk(OP_ADDIU, 32'h200, 1, 0, 0, 0, 0, 32'h10, 1, 3);
        step();
        enq_elem = mk(OP_ADDIU, 32'h204, 1, 3, 0, 0, 0, 32'h4, 1, 8);
        step();
        enq_valid = 1'b0;
        chk("raw_busy3_set", 128'(dut.u_sb.r_busy[3]), 128'(1));
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("raw_stall%0d", i), 128'(issue_valid), 128'(0));
            step();
        end
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        #1;
        chk("raw_release_valid", 128'(issue_valid), 128'(1));
        chk("raw_release_num1", 128'(issue_elem.num1), 128'(32'h1234));
        step();
        wb_valid = 1'b0;
        chk("raw_busy3_clear", 128'(dut.u_sb.r_busy[3]), 128'(0));
        chk("raw_busy8_set", 128'(dut.u_sb.r_busy[8]), 128'(1));
        chk("raw_count", 128'(count), 128'(0));

        // Fill to full across the pointer wrap, then drain in order.
        do_reset();
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_elem = mk(OP_NOP, 32'(i), 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        enq_valid = 1'b0; issue_ready = 1'b1;
        step(); step(); step();
        issue_ready = 1'b0;
        chk("wrap_pre_count", 128'(count), 128'(0));
        enq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enq_elem = mk(OP_NOP, 32'(100 + i), 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        #1;
        chk("full_count", 128'(count), 128'(8));
        chk("full_enq_ready", 128'(enq_ready), 128'(0));
        // Full queue refuses an enqueue even while the head issues.
        enq_elem = mk(OP_NOP, 32'd99, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("drain%0d_valid", i), 128'(issue_valid), 128'(1));
            chk($sformatf("drain%0d_pc", i), 128'(issue_elem.pc), 128'(100 + i));
            step();
            enq_valid = 1'b0;
            if (i == 0) chk("full_stall_count", 128'(count), 128'(7));
        end
        chk("drain_count", 128'(count), 128'(0));
        issue_ready = 1'b0;

        // Write-after-write: writeback of A in the cycle B issues.
        do_reset();
        enq_valid = 1'b1;
        enq_elem = mk(OP_ADDIU, 32'h300, 0, 0, 0, 0, 0, 0, 1, 5);
        step();
        enq_elem = mk(OP_ADDIU, 32'h304, 0, 0, 0, 0, 0, 0, 1, 5);
        step();
        enq_valid = 1'b0; issue_ready = 1'b1;
        step();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hA;
        step();
        wb_valid = 1'b0;
        chk("waw_busy5_held", 128'(dut.u_sb.r_busy[5]), 128'(1));
        chk("waw_count", 128'(count), 128'(0));
        wb_valid = 1'b1; wb_data = 32'hB;
        step();
        wb_valid = 1'b0;
        chk("waw_busy5_clear", 128'(dut.u_sb.r_busy[5]), 128'(0));
        issue_ready = 1'b0;

        // Flush with 4 queued and a same-cycle enqueue.
        do_reset();
        enq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_elem = mk(OP_NOP, 32'(10 + i), 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        chk("flush_pre_count", 128'(count), 128'(4));
        flush = 1'b1;
        enq_elem = mk(OP_NOP, 32'd99, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("flush_cycle_valid", 128'(issue_valid), 128'(0));
        step();
        flush = 1'b0; enq_valid = 1'b0;
        #1;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(issue_valid), 128'(0));
        enq_valid = 1'b1;
        enq_elem = mk(OP_NOP, 32'd20, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        enq_valid = 1'b0;
        #1;
        chk("post_flush_count", 128'(count), 128'(1));
        chk("post_flush_pc", 128'(issue_elem.pc), 128'(20));

        // Reset in the middle of a burst with count=3.
        do_reset();
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_elem = mk(OP_ADDIU, 32'(50 + i), 0, 0, 0, 0, 0, 0, 1, 5'(7 + i));
            step();
        end
        enq_valid = 1'b0; issue_ready = 1'b1;
        step();
        issue_ready = 1'b0; enq_valid = 1'b1;
        enq_elem = mk(OP_NOP, 32'd60, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mid_pre_count", 128'(count), 128'(3));
        chk("mid_pre_busy7", 128'(dut.u_sb.r_busy[7]), 128'(1));
        rst_n = 1'b0;
        step();
        enq_valid = 1'b0;
        #1;
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_valid", 128'(issue_valid), 128'(0));
        chk("mid_rst_busy", 128'(dut.u_sb.r_busy), 128'(0));
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
